// File: rtl/cm_ahb_pkg.sv
// AHB-Lite encodings and request-stage state type shared by the matrix master-side logic.
package cm_ahb_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] HB_INCR  = 3'b001;
    localparam logic [2:0] HB_INCR4 = 3'b011;

    localparam logic HR_OKAY  = 1'b0;
    localparam logic HR_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND,
        ST_DATA
    } state_e;

    // NONSEQ and SEQ both carry a real transfer; IDLE and BUSY do not.
    function automatic logic ht_active(input logic [1:0] t);
        return t[1];
    endfunction

endpackage

// File: rtl/cm_mst_req_stage_if.sv
// Master-side AHB-Lite bus seen by one matrix request stage, plus the external slave decode.
interface cm_mst_req_stage_if #(
    parameter int NUM_SLV = 2,
    parameter int AW      = 32,
    parameter int DW      = 32
);
    logic               hsel;
    logic [NUM_SLV-1:0] hsel_dec;
    logic [AW-1:0]      haddr;
    logic [1:0]         htrans;
    logic               hwrite;
    logic [2:0]         hsize;
    logic [2:0]         hburst;
    logic [3:0]         hprot;
    logic               hmastlock;
    logic [DW-1:0]      hwdata;
    logic               hready;
    logic               hreadyout;
    logic               hresp;
    logic [DW-1:0]      hrdata;

    modport master (
        output hsel, hsel_dec, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata,
        input  hready, hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, hsel_dec, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata,
        input  hready,
        output hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/cm_resp_mux.sv
// One-hot selection of the data-phase slave's ready/response/read data; all-zero select yields zeros.
module cm_resp_mux #(
    parameter int NUM_SLV = 2,
    parameter int DW      = 32
) (
    input  logic [NUM_SLV-1:0]    sel,
    input  logic [NUM_SLV-1:0]    s_hreadyout,
    input  logic [NUM_SLV-1:0]    s_hresp,
    input  logic [NUM_SLV*DW-1:0] s_hrdata,
    output logic                  hreadyout,
    output logic                  hresp,
    output logic [DW-1:0]         hrdata
);

    always_comb begin
        hreadyout = 1'b0;
        hresp     = 1'b0;
        hrdata    = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (sel[i]) begin
                hreadyout = hreadyout | s_hreadyout[i];
                hresp     = hresp | s_hresp[i];
                hrdata    = hrdata | s_hrdata[i*DW +: DW];
            end
        end
    end

endmodule

// File: rtl/cm_mst_req_stage.sv
// Master-side request stage: latches an address phase, requests the target slave's arbiter,
// issues on grant and routes the slave's data-phase response back to the master.
module cm_mst_req_stage
    import cm_ahb_pkg::*;
#(
    parameter int NUM_SLV = 2,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    cm_mst_req_stage_if.slave     mst,
    output logic [NUM_SLV-1:0]    req,
    output logic                  lock,
    input  logic [NUM_SLV-1:0]    gnt,
    output logic [AW-1:0]         o_haddr,
    output logic [1:0]            o_htrans,
    output logic                  o_hwrite,
    output logic [2:0]            o_hsize,
    output logic [2:0]            o_hburst,
    output logic [3:0]            o_hprot,
    output logic                  o_hmastlock,
    output logic [DW-1:0]         o_hwdata,
    input  logic [NUM_SLV-1:0]    s_hreadyout,
    input  logic [NUM_SLV-1:0]    s_hresp,
    input  logic [NUM_SLV*DW-1:0] s_hrdata
);

    state_e             state_p0;
    logic [NUM_SLV-1:0] tgt_p0;
    logic [NUM_SLV-1:0] dslv_p0;
    logic [AW-1:0]      haddr_p0;
    logic [1:0]         htrans_p0;
    logic               hwrite_p0;
    logic [2:0]         hsize_p0;
    logic [2:0]         hburst_p0;
    logic [3:0]         hprot_p0;
    logic               hmastlock_p0;
    logic               seq_ok_p0;
    logic               brk_p0;
    logic               err2_p0;

    logic               mux_rdy;
    logic               mux_resp;
    logic [DW-1:0]      mux_rdata;
    logic [NUM_SLV-1:0] mux_sel;
    logic               local_err;
    logic               done;
    logic               accept;
    logic               issue;
    logic               fwd_seq;

    assign mux_sel = (state_p0 == ST_DATA) ? dslv_p0 : '0;

    cm_resp_mux #(
        .NUM_SLV (NUM_SLV),
        .DW      (DW)
    ) u_resp_mux (
        .sel         (mux_sel),
        .s_hreadyout (s_hreadyout),
        .s_hresp     (s_hresp),
        .s_hrdata    (s_hrdata),
        .hreadyout   (mux_rdy),
        .hresp       (mux_resp),
        .hrdata      (mux_rdata)
    );

    // A data phase with no slave selected is the locally generated two-cycle ERROR.
    assign local_err = (state_p0 == ST_DATA) && (dslv_p0 == '0);
    assign done      = (state_p0 == ST_DATA) && (local_err ? err2_p0 : mux_rdy);
    assign accept    = mst.hready && mst.hsel && ht_active(mst.htrans)
                       && ((state_p0 == ST_IDLE) || done);
    assign issue     = (state_p0 == ST_PEND) && ((gnt & tgt_p0) != '0);
    assign fwd_seq   = (htrans_p0 == HT_SEQ) && seq_ok_p0;

    always_comb begin
        mst.hreadyout = 1'b1;
        mst.hresp     = HR_OKAY;
        mst.hrdata    = mux_rdata;
        case (state_p0)
            ST_PEND: mst.hreadyout = 1'b0;
            ST_DATA: begin
                mst.hreadyout = local_err ? err2_p0 : mux_rdy;
                mst.hresp     = local_err ? HR_ERROR : mux_resp;
            end
            default: ;
        endcase
    end

    assign req         = (state_p0 == ST_PEND) ? tgt_p0 : '0;
    assign lock        = (state_p0 != ST_IDLE) && hmastlock_p0;
    assign o_haddr     = haddr_p0;
    assign o_hwrite    = hwrite_p0;
    assign o_hsize     = hsize_p0;
    assign o_hprot     = hprot_p0;
    assign o_hmastlock = hmastlock_p0;
    assign o_htrans    = !issue ? HT_IDLE : (fwd_seq ? HT_SEQ : HT_NONSEQ);
    // Once a burst has been broken by a slave switch its remaining beats stay undefined-length.
    assign o_hburst    = ((htrans_p0 == HT_SEQ) && (!fwd_seq || brk_p0)) ? HB_INCR : hburst_p0;
    assign o_hwdata    = (state_p0 == ST_DATA) ? mst.hwdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0     <= ST_IDLE;
            tgt_p0       <= '0;
            dslv_p0      <= '0;
            haddr_p0     <= '0;
            htrans_p0    <= HT_IDLE;
            hwrite_p0    <= 1'b0;
            hsize_p0     <= '0;
            hburst_p0    <= '0;
            hprot_p0     <= '0;
            hmastlock_p0 <= 1'b0;
            seq_ok_p0    <= 1'b0;
            brk_p0       <= 1'b0;
            err2_p0      <= 1'b0;
        end else begin
            case (state_p0)
                ST_PEND: begin
                    if (issue) begin
                        dslv_p0  <= tgt_p0;
                        state_p0 <= ST_DATA;
                        if (htrans_p0 == HT_NONSEQ) brk_p0 <= 1'b0;
                        else if (!fwd_seq)          brk_p0 <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (local_err) err2_p0 <= 1'b1;
                    if (done)      state_p0 <= ST_IDLE;
                end
                default: ;
            endcase

            // Accept stage: capture the master's address phase, overriding the state update above.
            if (accept) begin
                haddr_p0     <= mst.haddr;
                htrans_p0    <= mst.htrans;
                hwrite_p0    <= mst.hwrite;
                hsize_p0     <= mst.hsize;
                hburst_p0    <= mst.hburst;
                hprot_p0     <= mst.hprot;
                hmastlock_p0 <= mst.hmastlock;
                tgt_p0       <= mst.hsel_dec;
                seq_ok_p0    <= done && !local_err && (mst.hsel_dec == dslv_p0);
                err2_p0      <= 1'b0;
                if (mst.hsel_dec == '0) begin
                    dslv_p0  <= '0;
                    state_p0 <= ST_DATA;
                end else begin
                    state_p0 <= ST_PEND;
                end
            end
        end
    end

endmodule

// File: tb/tb_cm_mst_req_stage.sv
// Directed and randomized transfer sequences checked against a transaction-level expectation model.
module tb_cm_mst_req_stage;
    import cm_ahb_pkg::*;

    localparam int NS = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NS-1:0]     req;
    logic              lock;
    logic [NS-1:0]     gnt;
    logic [AW-1:0]     o_haddr;
    logic [1:0]        o_htrans;
    logic              o_hwrite;
    logic [2:0]        o_hsize;
    logic [2:0]        o_hburst;
    logic [3:0]        o_hprot;
    logic              o_hmastlock;
    logic [DW-1:0]     o_hwdata;
    logic [NS-1:0]     s_hreadyout;
    logic [NS-1:0]     s_hresp;
    logic [NS*DW-1:0]  s_hrdata;

    int errors = 0;
    int checks = 0;

    cm_mst_req_stage_if #(.NUM_SLV(NS), .AW(AW), .DW(DW)) mif ();
    assign mif.hready = mif.hreadyout;

    cm_mst_req_stage #(.NUM_SLV(NS), .AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .mst         (mif.slave),
        .req         (req),
        .lock        (lock),
        .gnt         (gnt),
        .o_haddr     (o_haddr),
        .o_htrans    (o_htrans),
        .o_hwrite    (o_hwrite),
        .o_hsize     (o_hsize),
        .o_hburst    (o_hburst),
        .o_hprot     (o_hprot),
        .o_hmastlock (o_hmastlock),
        .o_hwdata    (o_hwdata),
        .s_hreadyout (s_hreadyout),
        .s_hresp     (s_hresp),
        .s_hrdata    (s_hrdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          slv;
        logic [1:0]  tr;
        logic [2:0]  bu;
        logic        wr;
        logic        lk;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gdly;
        int          wst;
        logic        serr;
        logic [1:0]  exp_tr;
        logic [2:0]  exp_bu;
    } beat_t;

    beat_t bt[8];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic beat_t mk(input int slv, input logic [1:0] tr, input logic [2:0] bu,
                                 input logic wr, input int gdly, input int wst, input logic serr);
        beat_t b;
        b.slv = slv; b.tr = tr; b.bu = bu; b.wr = wr; b.lk = 1'b0;
        b.addr = $urandom; b.wdata = $urandom; b.rdata = $urandom;
        b.gdly = gdly; b.wst = wst; b.serr = serr;
        b.exp_tr = HT_IDLE; b.exp_bu = 3'b000;
        return b;
    endfunction

    function automatic logic [NS-1:0] onehot(input int slv);
        logic [NS-1:0] v;
        v = '0;
        if (slv >= 0) v[slv] = 1'b1;
        return v;
    endfunction

    // What the slave should see for each beat: a SEQ survives only when it chains
    // directly onto an issued beat to the same slave; a broken burst degrades to INCR.
    task automatic prep(input int n);
        int   prev;
        logic broken;
        prev = -1;
        broken = 1'b0;
        for (int b = 0; b < n; b++) begin
            if (bt[b].slv < 0) begin
                prev = -1;
            end else begin
                if (bt[b].tr == HT_NONSEQ) begin
                    bt[b].exp_tr = HT_NONSEQ; bt[b].exp_bu = bt[b].bu; broken = 1'b0;
                end else if (bt[b].slv == prev) begin
                    bt[b].exp_tr = HT_SEQ; bt[b].exp_bu = broken ? HB_INCR : bt[b].bu;
                end else begin
                    bt[b].exp_tr = HT_NONSEQ; bt[b].exp_bu = HB_INCR; broken = 1'b1;
                end
                prev = bt[b].slv;
            end
        end
    endtask

    task automatic drive_addr(input int b);
        mif.hsel      = 1'b1;
        mif.hsel_dec  = onehot(bt[b].slv);
        mif.haddr     = bt[b].addr;
        mif.htrans    = bt[b].tr;
        mif.hwrite    = bt[b].wr;
        mif.hsize     = 3'b010;
        mif.hburst    = bt[b].bu;
        mif.hprot     = 4'b0011;
        mif.hmastlock = bt[b].lk;
    endtask

    task automatic drive_idle();
        mif.hsel      = 1'b1;
        mif.hsel_dec  = '0;
        mif.htrans    = HT_IDLE;
        mif.hmastlock = 1'b0;
    endtask

    task automatic slaves_idle();
        s_hreadyout = '1;
        s_hresp     = '0;
        s_hrdata    = {$urandom, $urandom};
    endtask

    task automatic run(input string nm, input int n);
        logic [NS-1:0] oh;
        logic [NS-1:0] r;
        prep(n);
        step();
        drive_addr(0); gnt = '0; slaves_idle();
        @(negedge clk);
        chk({nm, " acc_rdy"}, mif.hreadyout, 1'b1);
        chk({nm, " acc_req"}, req, '0);
        chk({nm, " acc_otr"}, o_htrans, HT_IDLE);
        for (int b = 0; b < n; b++) begin
            step();
            if (b + 1 < n) drive_addr(b + 1); else drive_idle();
            mif.hwdata = bt[b].wdata;
            if (bt[b].slv < 0) begin
                @(negedge clk);
                chk($sformatf("%s b%0d lerr1_req", nm, b), req, '0);
                chk($sformatf("%s b%0d lerr1_rdy", nm, b), mif.hreadyout, 1'b0);
                chk($sformatf("%s b%0d lerr1_rsp", nm, b), mif.hresp, 1'b1);
                step();
                @(negedge clk);
                chk($sformatf("%s b%0d lerr2_rdy", nm, b), mif.hreadyout, 1'b1);
                chk($sformatf("%s b%0d lerr2_rsp", nm, b), mif.hresp, 1'b1);
            end else begin
                oh = onehot(bt[b].slv);
                for (int k = 0; k < bt[b].gdly; k++) begin
                    gnt = NS'($urandom) & ~oh;
                    @(negedge clk);
                    chk($sformatf("%s b%0d wait%0d_req", nm, b, k), req, oh);
                    chk($sformatf("%s b%0d wait%0d_rdy", nm, b, k), mif.hreadyout, 1'b0);
                    chk($sformatf("%s b%0d wait%0d_otr", nm, b, k), o_htrans, HT_IDLE);
                    step();
                end
                gnt = oh | NS'($urandom);
                @(negedge clk);
                chk($sformatf("%s b%0d iss_req", nm, b), req, oh);
                chk($sformatf("%s b%0d iss_otr", nm, b), o_htrans, bt[b].exp_tr);
                chk($sformatf("%s b%0d iss_obu", nm, b), o_hburst, bt[b].exp_bu);
                chk($sformatf("%s b%0d iss_adr", nm, b), o_haddr, bt[b].addr);
                chk($sformatf("%s b%0d iss_wr", nm, b), o_hwrite, bt[b].wr);
                chk($sformatf("%s b%0d iss_ctl", nm, b), {o_hsize, o_hprot}, {3'b010, 4'b0011});
                chk($sformatf("%s b%0d iss_lock", nm, b), {lock, o_hmastlock}, {bt[b].lk, bt[b].lk});
                step();
                gnt = NS'($urandom);
                for (int w = 0; w < bt[b].wst; w++) begin
                    r = NS'($urandom); r[bt[b].slv] = 1'b0; s_hreadyout = r;
                    r = NS'($urandom); r[bt[b].slv] = 1'b0; s_hresp = r;
                    @(negedge clk);
                    chk($sformatf("%s b%0d ws%0d_rdy", nm, b, w), mif.hreadyout, 1'b0);
                    chk($sformatf("%s b%0d ws%0d_rsp", nm, b, w), mif.hresp, 1'b0);
                    chk($sformatf("%s b%0d ws%0d_wd", nm, b, w), o_hwdata, bt[b].wdata);
                    step();
                end
                if (bt[b].serr) begin
                    s_hreadyout[bt[b].slv] = 1'b0; s_hresp[bt[b].slv] = 1'b1;
                    @(negedge clk);
                    chk($sformatf("%s b%0d err1_rdy", nm, b), mif.hreadyout, 1'b0);
                    chk($sformatf("%s b%0d err1_rsp", nm, b), mif.hresp, 1'b1);
                    step();
                end
                s_hreadyout = NS'($urandom);
                s_hreadyout[bt[b].slv] = 1'b1;
                s_hresp = NS'($urandom);
                s_hresp[bt[b].slv] = bt[b].serr;
                s_hrdata = {$urandom, $urandom};
                s_hrdata[bt[b].slv*DW +: DW] = bt[b].rdata;
                @(negedge clk);
                chk($sformatf("%s b%0d fin_rdy", nm, b), mif.hreadyout, 1'b1);
                chk($sformatf("%s b%0d fin_rsp", nm, b), mif.hresp, bt[b].serr);
                if (bt[b].wr) chk($sformatf("%s b%0d fin_wd", nm, b), o_hwdata, bt[b].wdata);
                else          chk($sformatf("%s b%0d fin_rd", nm, b), mif.hrdata, bt[b].rdata);
            end
        end
        step();
        drive_idle(); gnt = '0; slaves_idle();
        @(negedge clk);
        chk({nm, " end_req"}, req, '0);
        chk({nm, " end_rdy"}, mif.hreadyout, 1'b1);
        chk({nm, " end_rsp"}, mif.hresp, 1'b0);
        chk({nm, " end_lock"}, lock, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        gnt = '0;
        mif.hwdata = '0;
        mif.haddr = '0; mif.hwrite = 1'b0; mif.hsize = '0; mif.hburst = '0; mif.hprot = '0;
        drive_idle();
        slaves_idle();
        step(); step();
        @(negedge clk);
        chk("rst_rdy", mif.hreadyout, 1'b1);
        chk("rst_rsp", mif.hresp, 1'b0);
        chk("rst_rdata", mif.hrdata, '0);
        chk("rst_req", req, '0);
        chk("rst_lock", lock, 1'b0);
        chk("rst_otr", o_htrans, HT_IDLE);
        step();
        rst = 1'b0;

        // Single write to slave 1, grant one cycle after the request.
        bt[0] = mk(1, HT_NONSEQ, HB_INCR, 1'b1, 1, 0, 1'b0);
        run("t1", 1);

        // Grant withheld five cycles.
        bt[0] = mk(1, HT_NONSEQ, HB_INCR, 1'b0, 5, 1, 1'b0);
        bt[0].lk = 1'b1;
        run("t2", 1);

        // INCR4 to slave 0, then the same burst switching to slave 1 at beat 3.
        bt[0] = mk(0, HT_NONSEQ, HB_INCR4, 1'b1, 0, 0, 1'b0);
        for (int i = 1; i < 4; i++) bt[i] = mk(0, HT_SEQ, HB_INCR4, 1'b1, 0, 0, 1'b0);
        run("t3a", 4);
        bt[0] = mk(0, HT_NONSEQ, HB_INCR4, 1'b1, 0, 0, 1'b0);
        for (int i = 1; i < 4; i++) bt[i] = mk(i < 2 ? 0 : 1, HT_SEQ, HB_INCR4, 1'b1, 0, 0, 1'b0);
        run("t3b", 4);

        // Slave ERROR on a read, master then idles.
        bt[0] = mk(0, HT_NONSEQ, HB_INCR, 1'b0, 0, 0, 1'b1);
        run("t4", 1);

        // No slave decoded: local ERROR.
        bt[0] = mk(-1, HT_NONSEQ, HB_INCR, 1'b1, 0, 0, 1'b0);
        run("t5", 1);

        // BUSY with hsel gives a zero-wait OKAY and raises nothing.
        step();
        mif.hsel = 1'b1; mif.hsel_dec = 2'b01; mif.htrans = HT_BUSY;
        @(negedge clk);
        chk("busy_rdy", mif.hreadyout, 1'b1);
        chk("busy_rsp", mif.hresp, 1'b0);
        step();
        drive_idle();
        @(negedge clk);
        chk("busy_req", req, '0);
        chk("busy_otr", o_htrans, HT_IDLE);

        // Reset while a locked transfer sits in its data phase.
        bt[0] = mk(1, HT_NONSEQ, HB_INCR, 1'b1, 0, 0, 1'b0);
        bt[0].lk = 1'b1;
        step(); drive_addr(0);
        step(); gnt = 2'b10;
        step(); gnt = '0; s_hreadyout = 2'b01;
        @(negedge clk);
        chk("t6_data_lock", lock, 1'b1);
        chk("t6_data_rdy", mif.hreadyout, 1'b0);
        step(); rst = 1'b1; gnt = 2'b10;
        step();
        @(negedge clk);
        chk("t6_req", req, '0);
        chk("t6_lock", lock, 1'b0);
        chk("t6_rdy", mif.hreadyout, 1'b1);
        chk("t6_otr", o_htrans, HT_IDLE);
        step(); rst = 1'b0; gnt = '0; drive_idle(); slaves_idle();
        @(negedge clk);
        chk("t6_post_req", req, '0);
        chk("t6_post_otr", o_htrans, HT_IDLE);

        // Randomized chains of beats.
        for (int it = 0; it < 12; it++) begin
            int n;
            n = $urandom_range(1, 6);
            for (int b = 0; b < n; b++) begin
                bt[b] = mk(($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 1)),
                           (b == 0 || $urandom_range(0, 2) == 0) ? HT_NONSEQ : HT_SEQ,
                           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                           $urandom_range(0, 3), $urandom_range(0, 2),
                           1'($urandom_range(0, 5) == 0));
                bt[b].lk = 1'($urandom_range(0, 1));
            end
            run($sformatf("rnd%0d", it), n);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
